// File: rtl/fifo2_sync.sv
// fifo2_sync: single-clock parametrised FIFO with almost-full/empty thresholds, occupancy count and sticky error flags.
// Latency: a write is visible (rempty low, count, FWFT rdata) one cycle after its edge; FWFT=0 rdata is valid the cycle after the rinc cycle.
// Backpressure: writes are dropped while wfull (sets overflow), reads are ignored while rempty (sets underflow); producer/consumer must honour the flags.
//
// Ports:
//   clk, rst                 single clock (rising edge), asynchronous active-high reset
//   wdata, winc              write data and write request
//   wfull, walmost_full      full (count == 2^ASIZE) and count >= AFULL_TH
//   rinc, rdata              read/pop request and read data (registered or fall-through per FWFT)
//   rempty, ralmost_empty    empty (count == 0) and count <= AEMPTY_TH
//   count                    occupancy 0..2^ASIZE
//   overflow, underflow      sticky error flags, cleared synchronously by clr_err
module fifo2_sync #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int             DEPTH    = 1 << ASIZE;
  localparam logic [ASIZE:0] FULL_CNT = DEPTH[ASIZE:0];
  localparam logic [ASIZE:0] AF_CNT   = AFULL_TH[ASIZE:0];
  localparam logic [ASIZE:0] AE_CNT   = AEMPTY_TH[ASIZE:0];
  localparam logic [ASIZE:0] PTR_ONE  = {{ASIZE{1'b0}}, 1'b1};

  if (ASIZE < 1 || AFULL_TH < 1 || AFULL_TH > DEPTH ||
      AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_param_check
    $error("fifo2_sync: illegal ASIZE/AFULL_TH/AEMPTY_TH parameter value");
  end

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic [ASIZE:0]   wptr_nxt;
  logic [ASIZE:0]   rptr_nxt;
  logic [ASIZE:0]   cnt_nxt;
  logic             wr_ok;
  logic             rd_ok;

  // Acceptance uses the registered (pre-edge) flags, so a full FIFO with
  // winc+rinc pops but drops the write, and an empty FIFO never bypasses.
  always_comb begin
    wr_ok    = winc && !wfull;
    rd_ok    = rinc && !rempty;
    wptr_nxt = wr_ok ? wptr + PTR_ONE : wptr;
    rptr_nxt = rd_ok ? rptr + PTR_ONE : rptr;
    // Extra pointer bit distinguishes full from empty when the low bits match.
    cnt_nxt  = wptr_nxt - rptr_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      wfull         <= 1'b0;
      walmost_full  <= 1'b0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      wptr          <= wptr_nxt;
      rptr          <= rptr_nxt;
      count         <= cnt_nxt;
      wfull         <= (cnt_nxt == FULL_CNT);
      walmost_full  <= (cnt_nxt >= AF_CNT);
      rempty        <= (cnt_nxt == '0);
      ralmost_empty <= (cnt_nxt <= AE_CNT);
      // A fresh error wins over a simultaneous clear.
      if (winc && wfull) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rinc && rempty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset; every read path below only exposes
  // locations written since the last reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr[ASIZE-1:0]] <= wdata;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is shown directly; forced to zero while empty so stale
    // memory contents never leak after reset or a full drain.
    assign rdata = rempty ? '0 : mem[rptr[ASIZE-1:0]];
  end else begin : g_std
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata <= '0;
      end else if (rd_ok) begin
        rdata <= mem[rptr[ASIZE-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_fifo2_sync.sv
module tb_fifo2_sync;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] wdata = '0;
  logic          winc = 1'b0;
  logic          rinc = 1'b0;
  logic          clr_err = 1'b0;

  // Standard-read instance
  logic          wfull0, walmost_full0, rempty0, ralmost_empty0, overflow0, underflow0;
  logic [DW-1:0] rdata0;
  logic [AW:0]   count0;
  // Fall-through instance
  logic          wfull1, walmost_full1, rempty1, ralmost_empty1, overflow1, underflow1;
  logic [DW-1:0] rdata1;
  logic [AW:0]   count1;

  fifo2_sync #(.DSIZE(DW), .ASIZE(AW), .FWFT(0), .AFULL_TH(14), .AEMPTY_TH(2)) dut0 (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .wfull(wfull0),
    .walmost_full(walmost_full0), .rinc(rinc), .rdata(rdata0), .rempty(rempty0),
    .ralmost_empty(ralmost_empty0), .count(count0), .overflow(overflow0),
    .underflow(underflow0), .clr_err(clr_err)
  );

  fifo2_sync #(.DSIZE(DW), .ASIZE(AW), .FWFT(1), .AFULL_TH(14), .AEMPTY_TH(2)) dut1 (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .wfull(wfull1),
    .walmost_full(walmost_full1), .rinc(rinc), .rdata(rdata1), .rempty(rempty1),
    .ralmost_empty(ralmost_empty1), .count(count1), .overflow(overflow1),
    .underflow(underflow1), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural reference: a queue of stored words plus sticky flags.
  logic [DW-1:0] mq[$];
  logic          m_ovf;
  logic          m_unf;
  logic [DW-1:0] m_rd0;

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rd0 = '0;
  endtask

  task automatic model_step(input logic w, input logic [DW-1:0] wd, input logic r, input logic c);
    bit full;
    bit empty;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    if (r && !empty) m_rd0 = mq.pop_front();
    if (w && !full)  mq.push_back(wd);
    m_ovf = (w && full)  ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_unf = (r && empty) ? 1'b1 : (c ? 1'b0 : m_unf);
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count0"},  32'(count0),         32'(n));
    chk({tag, ".wfull0"},  32'(wfull0),         32'(n == DEPTH));
    chk({tag, ".afull0"},  32'(walmost_full0),  32'(n >= 14));
    chk({tag, ".rempty0"}, 32'(rempty0),        32'(n == 0));
    chk({tag, ".aempty0"}, 32'(ralmost_empty0), 32'(n <= 2));
    chk({tag, ".ovf0"},    32'(overflow0),      32'(m_ovf));
    chk({tag, ".unf0"},    32'(underflow0),     32'(m_unf));
    chk({tag, ".rdata0"},  32'(rdata0),         32'(m_rd0));
    chk({tag, ".count1"},  32'(count1),         32'(n));
    chk({tag, ".wfull1"},  32'(wfull1),         32'(n == DEPTH));
    chk({tag, ".rempty1"}, 32'(rempty1),        32'(n == 0));
    chk({tag, ".ovf1"},    32'(overflow1),      32'(m_ovf));
    chk({tag, ".unf1"},    32'(underflow1),     32'(m_unf));
    if (n > 0) chk({tag, ".rdata1"}, 32'(rdata1), 32'(mq[0]));
  endtask

  // One clock: drive inputs, let the edge happen, update model, sample at +1.
  task automatic step(input string tag, input logic w, input logic [DW-1:0] wd,
                      input logic r, input logic c);
    winc = w; wdata = wd; rinc = r; clr_err = c;
    @(posedge clk);
    model_step(w, wd, r, c);
    #1;
    check_model(tag);
    winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
  endtask

  // Raise rst between edges and check that outputs clear before the next edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_model(tag);
    chk({tag, ".rdata1"},   32'(rdata1),         32'(0));
    chk({tag, ".aempty1"},  32'(ralmost_empty1), 32'(1));
    chk({tag, ".afull1"},   32'(walmost_full1),  32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic          w;
    logic [DW-1:0] wd;
    logic          r;
    logic          c;
    int            e_cnt;
    logic          e_full;
    logic          e_empty;
    logic          e_ovf;
    logic          e_unf;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic w, input logic [DW-1:0] wd, input logic r, input logic c,
                         input int e_cnt, input logic e_full, input logic e_empty,
                         input logic e_ovf, input logic e_unf, input logic [DW-1:0] e_rd);
    vec_t v;
    v.w = w; v.wd = wd; v.r = r; v.c = c;
    v.e_cnt = e_cnt; v.e_full = e_full; v.e_empty = e_empty;
    v.e_ovf = e_ovf; v.e_unf = e_unf; v.e_rd = e_rd;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string tg;
    logic  w, r, c;

    // Expected values for the directed sequence, from the FIFO rules.
    for (int i = 0; i < 16; i++)
      add_vec(1'b1, 8'(8'h11 + i), 1'b0, 1'b0, i + 1, i == 15, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++)
      add_vec(1'b0, 8'h00, 1'b1, 1'b0, 15 - i, 1'b0, i == 15, 1'b0, 1'b0, 8'(8'h11 + i));
    add_vec(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h20); // read while empty
    add_vec(1'b1, 8'hC3, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20); // w+r while empty
    add_vec(1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20); // clr_err
    for (int i = 0; i < 15; i++)
      add_vec(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, i + 2, i == 14, 1'b0, 1'b0, 1'b0, 8'h20);
    add_vec(1'b1, 8'hEE, 1'b1, 1'b0, 15, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC3); // w+r while full
    add_vec(1'b0, 8'h00, 1'b0, 1'b1, 15, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3); // clr_err
    add_vec(1'b0, 8'h00, 1'b0, 1'b0, 15, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3); // idle hold

    // Power-on reset state
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_model("por");
    chk("por.rdata1", 32'(rdata1), 32'(0));
    rst = 1'b0;
    step("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Directed table
    for (int i = 0; i < tbl.size(); i++) begin
      tg = $sformatf("tbl%0d", i);
      step(tg, tbl[i].w, tbl[i].wd, tbl[i].r, tbl[i].c);
      chk({tg, ".cnt"},   32'(count0),     32'(tbl[i].e_cnt));
      chk({tg, ".full"},  32'(wfull0),     32'(tbl[i].e_full));
      chk({tg, ".empty"}, 32'(rempty0),    32'(tbl[i].e_empty));
      chk({tg, ".ovf"},   32'(overflow0),  32'(tbl[i].e_ovf));
      chk({tg, ".unf"},   32'(underflow0), 32'(tbl[i].e_unf));
      chk({tg, ".rd"},    32'(rdata0),     32'(tbl[i].e_rd));
    end

    // Pointer wrap: 40 write/read pairs around the full boundary
    for (int i = 0; i < 40; i++) begin
      step($sformatf("wrapw%0d", i), 1'b1, 8'($urandom), 1'b0, 1'b0);
      step($sformatf("wrapr%0d", i), 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Randomised traffic: write-heavy then read-heavy phases reach both ends
    for (int i = 0; i < 300; i++) begin
      if (i < 150) begin
        w = ($urandom_range(0, 99) < 65);
        r = ($urandom_range(0, 99) < 40);
      end else begin
        w = ($urandom_range(0, 99) < 35);
        r = ($urandom_range(0, 99) < 65);
      end
      c = ($urandom_range(0, 99) < 6);
      step($sformatf("rnd%0d", i), w, 8'($urandom), r, c);
    end

    // Asynchronous reset with seven words held
    async_reset("rst0");
    for (int i = 0; i < 7; i++)
      step($sformatf("fill%0d", i), 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    chk("fill.count7", 32'(count0), 32'(7));
    async_reset("rst7");
    chk("rst7.count", 32'(count0), 32'(0));

    // Fall-through: word visible without rinc, popped by rinc
    step("fwft.w", 1'b1, 8'hA5, 1'b0, 1'b0);
    chk("fwft.rempty", 32'(rempty1), 32'(0));
    chk("fwft.rdata",  32'(rdata1),  32'(8'hA5));
    step("fwft.hold", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("fwft.hold.rdata", 32'(rdata1), 32'(8'hA5));
    step("fwft.pop", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft.pop.rempty", 32'(rempty1), 32'(1));
    chk("fwft.pop.rdata0", 32'(rdata0),  32'(8'hA5));

    // After reset only freshly written data is observable
    step("post.w", 1'b1, 8'h77, 1'b0, 1'b0);
    step("post.r", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("post.rdata0", 32'(rdata0), 32'(8'h77));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
